// File: rtl/led_pwm_driver.sv
// led_pwm_driver: N-channel LED driver with per-channel OFF/ON/PWM/BLINK
// modes. Settings land in shadow registers through a valid/ready write port
// and are copied to the active set only at PWM period boundaries, so a
// channel never shows a partially updated period.
module led_pwm_driver #(
   parameter int NUM_LEDS      = 8,
   parameter int PWM_BITS      = 8,
   parameter int PRESCALE      = 196,
   parameter int BLINK_PERIODS = 500,
   localparam int CW           = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                wr_valid,
   output logic                wr_ready,
   input  logic                wr_all,
   input  logic [CW-1:0]       wr_chan,
   input  logic [1:0]          wr_mode,
   input  logic [PWM_BITS-1:0] wr_duty,
   output logic                wr_err,
   output logic                period_start,
   output logic [NUM_LEDS-1:0] led
);

   localparam int PSW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int BCW = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;
   localparam logic [PSW-1:0] PRESC_LAST = PSW'(PRESCALE - 1);
   localparam logic [BCW-1:0] BLINK_LAST = BCW'(BLINK_PERIODS - 1);

   localparam logic [1:0] MODE_OFF   = 2'd0;
   localparam logic [1:0] MODE_ON    = 2'd1;
   localparam logic [1:0] MODE_PWM   = 2'd2;
   localparam logic [1:0] MODE_BLINK = 2'd3;

   logic [PSW-1:0]      presc;
   logic [PWM_BITS-1:0] pwm_cnt;
   logic [BCW-1:0]      blink_cnt;
   logic                blink_phase;
   logic                tick;
   logic                boundary;
   logic                wr_fire;
   logic                chan_bad;

   logic [1:0]          shadow_mode     [NUM_LEDS];
   logic [PWM_BITS-1:0] shadow_duty     [NUM_LEDS];
   logic [1:0]          shadow_mode_nxt [NUM_LEDS];
   logic [PWM_BITS-1:0] shadow_duty_nxt [NUM_LEDS];
   logic [1:0]          active_mode     [NUM_LEDS];
   logic [PWM_BITS-1:0] active_duty     [NUM_LEDS];
   logic [NUM_LEDS-1:0] led_nxt;

   // Drive level of one channel for the current counter position.
   // duty=0 never lights; duty=max leaves only the last tick dark.
   function automatic logic led_level(input logic [1:0]          mode,
                                      input logic [PWM_BITS-1:0] duty,
                                      input logic [PWM_BITS-1:0] cnt,
                                      input logic                phase);
      logic lvl;
      case (mode)
         MODE_OFF:   lvl = 1'b0;
         MODE_ON:    lvl = 1'b1;
         MODE_PWM:   lvl = (cnt < duty);
         default:    lvl = phase & (cnt < duty);
      endcase
      return lvl;
   endfunction

   assign tick     = (presc == PRESC_LAST);
   assign boundary = tick && (pwm_cnt == {PWM_BITS{1'b1}});
   assign wr_fire  = wr_valid && wr_ready;
   assign chan_bad = !wr_all && (32'(wr_chan) >= NUM_LEDS);

   // Timebase: prescaler, PWM counter, and the blink phase that advances on boundaries
   always_ff @(posedge clk) begin
      if (rst) begin
         presc       <= '0;
         pwm_cnt     <= '0;
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else begin
         presc <= tick ? '0 : presc + 1'b1;
         if (tick) begin
            pwm_cnt <= pwm_cnt + 1'b1;
         end
         if (boundary) begin
            if (blink_cnt == BLINK_LAST) begin
               blink_cnt   <= '0;
               blink_phase <= ~blink_phase;
            end else begin
               blink_cnt <= blink_cnt + 1'b1;
            end
         end
      end
   end

   // Shadow next-state: the accepted write folded in, so a write in the boundary cycle is copied too
   always_comb begin
      for (int i = 0; i < NUM_LEDS; i++) begin
         shadow_mode_nxt[i] = shadow_mode[i];
         shadow_duty_nxt[i] = shadow_duty[i];
         if (wr_fire && (wr_all || (32'(wr_chan) == i))) begin
            shadow_mode_nxt[i] = wr_mode;
            shadow_duty_nxt[i] = wr_duty;
         end
      end
   end

   // Shadow and active settings; active only changes at a period boundary
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_LEDS; i++) begin
            shadow_mode[i] <= MODE_OFF;
            shadow_duty[i] <= '0;
            active_mode[i] <= MODE_OFF;
            active_duty[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_LEDS; i++) begin
            shadow_mode[i] <= shadow_mode_nxt[i];
            shadow_duty[i] <= shadow_duty_nxt[i];
            if (boundary) begin
               active_mode[i] <= shadow_mode_nxt[i];
               active_duty[i] <= shadow_duty_nxt[i];
            end
         end
      end
   end

   // Per-channel drive level from the active settings and the current counters
   always_comb begin
      led_nxt = '0;
      for (int i = 0; i < NUM_LEDS; i++) begin
         led_nxt[i] = led_level(active_mode[i], active_duty[i], pwm_cnt, blink_phase);
      end
   end

   // Registered outputs: LED pins, boundary pulse, write handshake and error pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         led          <= '0;
         period_start <= 1'b0;
         wr_ready     <= 1'b0;
         wr_err       <= 1'b0;
      end else begin
         led          <= led_nxt;
         period_start <= boundary;
         wr_ready     <= 1'b1;
         wr_err       <= wr_fire && chan_bad;
      end
   end

endmodule

// File: tb/tb_led_pwm_driver.sv
// Bench for led_pwm_driver: directed scenarios plus random writes, all
// checked cycle by cycle against an arithmetic reference model. A second,
// otherwise idle, 5-channel instance provides a 3-bit channel field so an
// out-of-range channel number can actually be presented.
module tb_led_pwm_driver;

   localparam int N   = 4;
   localparam int B   = 4;
   localparam int P   = 2;
   localparam int BP  = 3;
   localparam int PER = P * (1 << B);

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wr_valid = 1'b0;
   logic       wr_all = 1'b0;
   logic [1:0] wr_chan = '0;
   logic [1:0] wr_mode = '0;
   logic [3:0] wr_duty = '0;
   logic       wr_ready, wr_err, period_start;
   logic [3:0] led;

   logic       wr_valid5 = 1'b0;
   logic [2:0] wr_chan5 = '0;
   logic       wr_ready5, wr_err5, period_start5;
   logic [4:0] led5;

   int checks = 0;
   int errors = 0;

   led_pwm_driver #(.NUM_LEDS(N), .PWM_BITS(B), .PRESCALE(P), .BLINK_PERIODS(BP)) dut (
      .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_all(wr_all),
      .wr_chan(wr_chan), .wr_mode(wr_mode), .wr_duty(wr_duty), .wr_err(wr_err),
      .period_start(period_start), .led(led));

   led_pwm_driver #(.NUM_LEDS(5), .PWM_BITS(B), .PRESCALE(P), .BLINK_PERIODS(BP)) dut5 (
      .clk(clk), .rst(rst), .wr_valid(wr_valid5), .wr_ready(wr_ready5), .wr_all(wr_all),
      .wr_chan(wr_chan5), .wr_mode(wr_mode), .wr_duty(wr_duty), .wr_err(wr_err5),
      .period_start(period_start5), .led(led5));

   always #5 clk = ~clk;

   // Reference model: n = clocks since reset release. Counter positions
   // come straight from n; the active set is a copy of the shadow set
   // taken each time n reaches a multiple of the period length.
   int         n;
   int         m_pwm, m_phase;
   int         m_sduty [N];
   int         m_aduty [N];
   int         m_smode [N];
   int         m_amode [N];
   logic [3:0] exp_led;
   logic       exp_ps, exp_ready;

   always @(posedge clk) begin
      if (rst) begin
         n = 0;
         for (int i = 0; i < N; i++) begin
            m_sduty[i] = 0; m_aduty[i] = 0; m_smode[i] = 0; m_amode[i] = 0;
         end
         exp_led = '0; exp_ps = 1'b0; exp_ready = 1'b0;
      end else begin
         m_pwm   = (n / P) % (1 << B);
         m_phase = ((n / PER) / BP) % 2;
         for (int i = 0; i < N; i++) begin
            case (m_amode[i])
               0: exp_led[i] = 1'b0;
               1: exp_led[i] = 1'b1;
               2: exp_led[i] = (m_pwm < m_aduty[i]);
               default: exp_led[i] = (m_phase == 1) && (m_pwm < m_aduty[i]);
            endcase
         end
         exp_ps = ((n + 1) % PER == 0);
         if (wr_valid && n >= 1) begin
            for (int i = 0; i < N; i++) begin
               if (wr_all || int'(wr_chan) == i) begin
                  m_smode[i] = int'(wr_mode);
                  m_sduty[i] = int'(wr_duty);
               end
            end
         end
         n = n + 1;
         if (n % PER == 0) begin
            for (int i = 0; i < N; i++) begin
               m_amode[i] = m_smode[i];
               m_aduty[i] = m_sduty[i];
            end
         end
         exp_ready = 1'b1;
      end
   end

   task automatic drive_write(input logic all, input int ch, input int mode, input int duty);
      wr_valid = 1'b1;
      wr_all   = all;
      wr_chan  = 2'(ch);
      wr_mode  = 2'(mode);
      wr_duty  = 4'(duty);
      @(negedge clk);
      wr_valid = 1'b0;
      wr_all   = 1'b0;
   endtask

   // Waits for the next period_start pulse; expiry counts as a failure.
   task automatic wait_ps();
      int k;
      k = 0;
      @(negedge clk);
      while (period_start !== 1'b1 && k < 200) begin
         @(negedge clk);
         k++;
      end
      checks++;
      if (k >= 200) begin
         errors++;
         $display("FAIL wait_ps: no period_start within 200 cycles (got %b, need 1)", period_start);
      end
   endtask

   // Measurement only: counts cycles led[ch] is high and cycles the DUT
   // disagrees with the model on any output.
   task automatic observe(input int ch, input int cyc, output int high, output int mm);
      high = 0;
      mm   = 0;
      repeat (cyc) begin
         @(negedge clk);
         if (led[ch] === 1'b1) high++;
         if (led !== exp_led || period_start !== exp_ps || wr_ready !== exp_ready ||
             wr_err !== 1'b0)
            mm++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (5) @(negedge clk);
      checks++;
      if (led !== 4'h0 || wr_ready !== 1'b0 || wr_err !== 1'b0 || period_start !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: led=%h rdy=%b err=%b ps=%b, need 0 0 0 0",
                  led, wr_ready, wr_err, period_start);
      end
      checks++;
      if (led5 !== 5'h0 || wr_ready5 !== 1'b0 || wr_err5 !== 1'b0) begin
         errors++;
         $display("FAIL reset_state5: led=%h rdy=%b err=%b, need 0 0 0", led5, wr_ready5, wr_err5);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (wr_ready !== 1'b1 || wr_ready5 !== 1'b1) begin
         errors++;
         $display("FAIL ready_after_reset: rdy=%b rdy5=%b, need 1 1", wr_ready, wr_ready5);
      end
   endtask

   task automatic test_pwm_duty4();
      int h, mm, h0, mm0;
      drive_write(1'b0, 1, 2, 4);
      wait_ps();
      observe(1, PER, h, mm);
      observe(0, PER, h0, mm0);
      checks++;
      if (h !== 8) begin
         errors++; $display("FAIL pwm_duty4: led1 high %0d clk per period, need 8", h);
      end
      checks++;
      if (h0 !== 0 || mm + mm0 !== 0) begin
         errors++; $display("FAIL pwm_duty4_model: led0 high %0d mism %0d, need 0 0", h0, mm + mm0);
      end
   endtask

   task automatic test_ch0_modes();
      int h, mm;
      int duty_tab [3] = '{0, 0, 15};
      int mode_tab [3] = '{2, 1, 2};
      int need_tab [3] = '{0, 32, 30};
      for (int t = 0; t < 3; t++) begin
         drive_write(1'b0, 0, mode_tab[t], duty_tab[t]);
         wait_ps();
         observe(0, PER, h, mm);
         checks++;
         if (h !== need_tab[t] || mm !== 0) begin
            errors++;
            $display("FAIL ch0_mode%0d_duty%0d: high %0d mism %0d, need %0d 0",
                     mode_tab[t], duty_tab[t], h, mm, need_tab[t]);
         end
      end
   endtask

   task automatic test_blink();
      int h, mm;
      drive_write(1'b0, 2, 3, 15);
      wait_ps();
      observe(2, 2 * BP * PER, h, mm);
      checks++;
      if (h !== 90 || mm !== 0) begin
         errors++; $display("FAIL blink: led2 high %0d in 192 clk, mism %0d, need 90 0", h, mm);
      end
   endtask

   task automatic test_bad_chan_and_all();
      int bad;
      int h, mm;
      wr_valid5 = 1'b1; wr_chan5 = 3'd5; wr_mode = 2'd1; wr_duty = 4'd7;
      @(negedge clk);
      wr_valid5 = 1'b0;
      checks++;
      if (wr_err5 !== 1'b1) begin
         errors++; $display("FAIL err_pulse: wr_err=%b, need 1", wr_err5);
      end
      @(negedge clk);
      checks++;
      if (wr_err5 !== 1'b0) begin
         errors++; $display("FAIL err_one_cycle: wr_err=%b, need 0", wr_err5);
      end
      bad = 0;
      repeat (2 * PER) begin
         @(negedge clk);
         if (led5 !== 5'h0 || wr_err5 !== 1'b0 || period_start5 !== period_start) bad++;
      end
      checks++;
      if (bad !== 0) begin
         errors++; $display("FAIL err_no_change: %0d bad cycles (led5=%h), need 0", bad, led5);
      end
      wr_valid5 = 1'b1; wr_chan5 = 3'd4; wr_mode = 2'd1;
      @(negedge clk);
      wr_valid5 = 1'b0;
      checks++;
      if (wr_err5 !== 1'b0) begin
         errors++; $display("FAIL err_valid_chan: wr_err=%b, need 0", wr_err5);
      end
      drive_write(1'b1, 0, 1, 0);
      wait_ps();
      @(negedge clk);
      checks++;
      if (led !== 4'hF || led5 !== 5'h10) begin
         errors++; $display("FAIL wr_all_on: led=%h led5=%h, need f 10", led, led5);
      end
      observe(3, PER, h, mm);
      checks++;
      if (h !== PER || mm !== 0) begin
         errors++; $display("FAIL wr_all_hold: led3 high %0d mism %0d, need 32 0", h, mm);
      end
   endtask

   task automatic test_back_to_back();
      int h, mm;
      wait_ps();
      drive_write(1'b0, 3, 2, 2);
      drive_write(1'b0, 3, 2, 9);
      wait_ps();
      observe(3, PER, h, mm);
      checks++;
      if (h !== 18 || mm !== 0) begin
         errors++; $display("FAIL last_write_wins: led3 high %0d mism %0d, need 18 0", h, mm);
      end
   endtask

   task automatic test_random();
      int h, mm;
      for (int it = 0; it < 40; it++) begin
         observe(0, $urandom_range(0, 20), h, mm);
         checks++;
         if (mm !== 0) begin
            errors++; $display("FAIL random_iter%0d: %0d mismatching cycles, need 0", it, mm);
         end
         drive_write(($urandom_range(0, 7) == 0), $urandom_range(0, 3),
                     $urandom_range(0, 3), $urandom_range(0, 15));
      end
      observe(0, 3 * PER, h, mm);
      checks++;
      if (mm !== 0) begin
         errors++; $display("FAIL random_tail: %0d mismatching cycles, need 0", mm);
      end
   endtask

   task automatic test_reset_mid();
      int h, mm;
      drive_write(1'b1, 0, 1, 0);
      wait_ps();
      repeat (7) @(negedge clk);
      checks++;
      if (led !== 4'hF) begin
         errors++; $display("FAIL pre_reset_on: led=%h, need f", led);
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (led !== 4'h0 || wr_ready !== 1'b0 || period_start !== 1'b0) begin
         errors++; $display("FAIL reset_mid: led=%h rdy=%b ps=%b, need 0 0 0", led, wr_ready, period_start);
      end
      rst = 1'b0;
      observe(0, 3 * PER, h, mm);
      checks++;
      if (h !== 0 || mm !== 0 || led !== 4'h0) begin
         errors++; $display("FAIL after_reset_off: high %0d mism %0d led=%h, need 0 0 0", h, mm, led);
      end
   endtask

   initial begin
      test_reset();
      test_pwm_duty4();
      test_ch0_modes();
      test_blink();
      test_bad_chan_and_all();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
